// File: rtl/pkt_to_msg_pkg.sv
// rtl/pkt_to_msg_pkg.sv - shared NIC widths and flit-type encodings
//
// Purpose: default bus/flit geometry for the NIC receive path and the
// two-bit flit-type codes carried alongside every flit.
package pkt_to_msg_pkg;

  localparam int DEF_FLIT_WIDTH        = 32;
  localparam int DEF_BUS_ADDRESS_WIDTH = 32;
  localparam int DEF_BUS_DATA_WIDTH    = 32;
  localparam int DEF_BUS_SEL_WIDTH     = 4;
  localparam int DEF_MAX_BURST_LENGHT  = 4;

  localparam logic [1:0] FLIT_HEAD     = 2'b00;
  localparam logic [1:0] FLIT_BODY     = 2'b01;
  localparam logic [1:0] FLIT_TAIL     = 2'b10;
  localparam logic [1:0] FLIT_HEADTAIL = 2'b11;

  // HEAD and HEADTAIL both open a new packet.
  function automatic logic starts_packet(input logic [1:0] flit_type);
    return (flit_type == FLIT_HEAD) || (flit_type == FLIT_HEADTAIL);
  endfunction

endpackage

// File: rtl/pkt_beat_buffer.sv
// rtl/pkt_beat_buffer.sv - indexed data/sel beat registers for packet reassembly
//
// Purpose: holds up to BEATS data beats and their byte selects.
// Ports:
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   clr_i          : clear all beats and selects (wins over we_i)
//   we_i, idx_i    : write wdata_i into beat idx_i and set its sel slice to all-ones
//   wdata_i        : beat payload
//   data_o, sel_o  : flattened beats, beat 0 in the LSBs
module pkt_beat_buffer #(
  parameter int BEATS = 4,
  parameter int DW    = 32,
  parameter int SW    = 4,
  parameter int IW    = 3
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                clr_i,
  input  logic                we_i,
  input  logic [IW-1:0]       idx_i,
  input  logic [DW-1:0]       wdata_i,
  output logic [BEATS*DW-1:0] data_o,
  output logic [BEATS*SW-1:0] sel_o
);

  logic [BEATS*DW-1:0] data_q;
  logic [BEATS*SW-1:0] sel_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      data_q <= '0;
      sel_q  <= '0;
    end else if (clr_i) begin
      data_q <= '0;
      sel_q  <= '0;
    end else if (we_i) begin
      // Out-of-range indices match no beat, so nothing is written.
      for (int k = 0; k < BEATS; k++) begin
        if (idx_i == IW'(k)) begin
          data_q[k*DW +: DW] <= wdata_i;
          sel_q[k*SW +: SW]  <= '1;
        end
      end
    end
  end

  assign data_o = data_q;
  assign sel_o  = sel_q;

endmodule

// File: rtl/pkt_to_msg.sv
// rtl/pkt_to_msg.sv - reassemble router flits into a WB-style bus message
//
// Purpose: accepts one flit per cycle, collects HEAD/BODY/TAIL packets and
// presents the decoded message on a valid/ack handshake.
// Ports:
//   clk_i, rst_n_i                    : clock, asynchronous active-low reset
//   flit_i, flit_type_i               : flit payload and type
//   flit_we_i, flit_reply_i           : write / reply flags, taken from head flits
//   flit_valid_i, flit_ready_o        : flit handshake
//   address_o, data_o, sel_o          : decoded message, beat 0 in the LSBs
//   burst_len_o                       : number of data beats received
//   WE_O, reply_for_wb_master_interface_o : latched head flags
//   msg_valid_o, msg_ack_i            : message handshake
//   err_o                             : pulse in the cycle a bad flit is accepted
module pkt_to_msg
  import pkt_to_msg_pkg::*;
#(
  parameter int FLIT_WIDTH        = DEF_FLIT_WIDTH,
  parameter int BUS_ADDRESS_WIDTH = DEF_BUS_ADDRESS_WIDTH,
  parameter int BUS_DATA_WIDTH    = DEF_BUS_DATA_WIDTH,
  parameter int BUS_SEL_WIDTH     = DEF_BUS_SEL_WIDTH,
  parameter int MAX_BURST_LENGHT  = DEF_MAX_BURST_LENGHT,
  localparam int CW = $clog2(MAX_BURST_LENGHT + 1)
) (
  input  logic                                   clk_i,
  input  logic                                   rst_n_i,
  input  logic [FLIT_WIDTH-1:0]                  flit_i,
  input  logic [1:0]                             flit_type_i,
  input  logic                                   flit_we_i,
  input  logic                                   flit_reply_i,
  input  logic                                   flit_valid_i,
  output logic                                   flit_ready_o,
  output logic [BUS_ADDRESS_WIDTH-1:0]           address_o,
  output logic [MAX_BURST_LENGHT*BUS_DATA_WIDTH-1:0] data_o,
  output logic [MAX_BURST_LENGHT*BUS_SEL_WIDTH-1:0]  sel_o,
  output logic [CW-1:0]                          burst_len_o,
  output logic                                   WE_O,
  output logic                                   reply_for_wb_master_interface_o,
  output logic                                   msg_valid_o,
  input  logic                                   msg_ack_i,
  output logic                                   err_o
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_PRESENT = 2'd2;

  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST_LENGHT);

  logic [1:0]                   state_q, state_d;
  logic [CW-1:0]                count_q;
  logic                         overflow_q;
  logic [BUS_ADDRESS_WIDTH-1:0] address_q;
  logic                         we_q;
  logic                         reply_q;

  logic accept;
  logic start;
  logic in_collect;
  logic is_data;
  logic room;
  logic buf_we;

  // Ready stays low while reset is asserted so every output reads zero.
  assign flit_ready_o = rst_n_i & (state_q != ST_PRESENT);
  assign accept       = flit_valid_i & flit_ready_o;
  assign start        = accept & starts_packet(flit_type_i);
  assign in_collect   = (state_q == ST_COLLECT);
  assign is_data      = (flit_type_i == FLIT_BODY) || (flit_type_i == FLIT_TAIL);
  assign room         = (count_q < MAX_CNT);
  assign buf_we       = accept & in_collect & is_data & room;

  // Errors: data flit with no open packet, a head aborting an open packet,
  // or a tail closing a packet that lost beats (including the tail itself).
  assign err_o = accept & (
                   (!in_collect & is_data) |
                   (in_collect & starts_packet(flit_type_i)) |
                   (in_collect & (flit_type_i == FLIT_TAIL) & (overflow_q | !room)));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_COLLECT: begin
        if (accept) begin
          if (flit_type_i == FLIT_HEADTAIL)
            state_d = ST_PRESENT;
          else if (flit_type_i == FLIT_HEAD)
            state_d = ST_COLLECT;
          else if (in_collect && flit_type_i == FLIT_TAIL)
            state_d = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (msg_ack_i)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      overflow_q <= 1'b0;
      address_q  <= '0;
      we_q       <= 1'b0;
      reply_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start) begin
        address_q  <= flit_i[BUS_ADDRESS_WIDTH-1:0];
        we_q       <= flit_we_i;
        reply_q    <= flit_reply_i;
        count_q    <= '0;
        overflow_q <= 1'b0;
      end else if (accept && in_collect && is_data) begin
        // Saturate at the burst limit; excess beats are dropped, not wrapped.
        if (room)
          count_q <= count_q + CW'(1);
        else
          overflow_q <= 1'b1;
      end
    end
  end

  pkt_beat_buffer #(
    .BEATS (MAX_BURST_LENGHT),
    .DW    (BUS_DATA_WIDTH),
    .SW    (BUS_SEL_WIDTH),
    .IW    (CW)
  ) u_beat_buffer (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clr_i   (start),
    .we_i    (buf_we),
    .idx_i   (count_q),
    .wdata_i (flit_i),
    .data_o  (data_o),
    .sel_o   (sel_o)
  );

  assign address_o                       = address_q;
  assign burst_len_o                     = count_q;
  assign WE_O                            = we_q;
  assign reply_for_wb_master_interface_o = reply_q;
  assign msg_valid_o                     = (state_q == ST_PRESENT);

endmodule

// File: tb/tb_pkt_to_msg.sv
// tb/tb_pkt_to_msg.sv - randomized self-checking bench for pkt_to_msg
module tb_pkt_to_msg;

  localparam int FW = 32;
  localparam int AW = 32;
  localparam int NB = 4;
  localparam int SW = 4;
  localparam int CW = 3;

  localparam logic [1:0] T_HEAD = 2'b00;
  localparam logic [1:0] T_BODY = 2'b01;
  localparam logic [1:0] T_TAIL = 2'b10;
  localparam logic [1:0] T_HT   = 2'b11;

  logic               clk_i = 1'b0;
  logic               rst_n_i = 1'b0;
  logic [FW-1:0]      flit_i = '0;
  logic [1:0]         flit_type_i = '0;
  logic               flit_we_i = 1'b0;
  logic               flit_reply_i = 1'b0;
  logic               flit_valid_i = 1'b0;
  logic               flit_ready_o;
  logic [AW-1:0]      address_o;
  logic [NB*FW-1:0]   data_o;
  logic [NB*SW-1:0]   sel_o;
  logic [CW-1:0]      burst_len_o;
  logic               WE_O;
  logic               reply_for_wb_master_interface_o;
  logic               msg_valid_o;
  logic               msg_ack_i = 1'b0;
  logic               err_o;

  always #5 clk_i = ~clk_i;

  pkt_to_msg dut (
    .clk_i                           (clk_i),
    .rst_n_i                         (rst_n_i),
    .flit_i                          (flit_i),
    .flit_type_i                     (flit_type_i),
    .flit_we_i                       (flit_we_i),
    .flit_reply_i                    (flit_reply_i),
    .flit_valid_i                    (flit_valid_i),
    .flit_ready_o                    (flit_ready_o),
    .address_o                       (address_o),
    .data_o                          (data_o),
    .sel_o                           (sel_o),
    .burst_len_o                     (burst_len_o),
    .WE_O                            (WE_O),
    .reply_for_wb_master_interface_o (reply_for_wb_master_interface_o),
    .msg_valid_o                     (msg_valid_o),
    .msg_ack_i                       (msg_ack_i),
    .err_o                           (err_o)
  );

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s obs=%0h exp=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Packet-level reference model: the open packet as a list of beats.
  typedef struct {
    logic [AW-1:0]    addr;
    logic             we;
    logic             rp;
    int               n;
    logic [NB*FW-1:0] data;
    logic [NB*SW-1:0] sel;
    int               vcyc;
  } msg_t;

  msg_t          exp_q[$];
  logic          m_active = 1'b0;
  logic [AW-1:0] m_addr;
  logic          m_we;
  logic          m_rp;
  logic [FW-1:0] m_beats[$];
  logic          m_over;

  task automatic push_msg();
    msg_t m;
    m.addr = m_addr;
    m.we   = m_we;
    m.rp   = m_rp;
    m.n    = m_beats.size();
    m.data = '0;
    m.sel  = '0;
    for (int i = 0; i < m_beats.size(); i++) begin
      m.data[i*FW +: FW] = m_beats[i];
      m.sel[i*SW +: SW]  = '1;
    end
    m.vcyc = cyc + 1;
    exp_q.push_back(m);
  endtask

  task automatic model_accept(input logic [1:0] t, input logic [FW-1:0] d,
                              input logic we, input logic rp, output logic err);
    err = 1'b0;
    if (t == T_HEAD || t == T_HT) begin
      err    = m_active;
      m_addr = d[AW-1:0];
      m_we   = we;
      m_rp   = rp;
      m_beats.delete();
      m_over   = 1'b0;
      m_active = (t == T_HEAD);
      if (t == T_HT) push_msg();
    end else if (!m_active) begin
      err = 1'b1;
    end else begin
      if (m_beats.size() < NB) m_beats.push_back(d);
      else m_over = 1'b1;
      if (t == T_TAIL) begin
        err = m_over;
        push_msg();
        m_active = 1'b0;
      end
    end
  endtask

  int acc_cyc  = 0;
  int drop_cyc = 0;
  int ack_cfg  = -1;
  logic presenting = 1'b0;

  task automatic scramble_idle_inputs();
    flit_valid_i = 1'b0;
    flit_type_i  = 2'($urandom);
    flit_i       = $urandom;
    flit_we_i    = 1'($urandom);
    flit_reply_i = 1'($urandom);
  endtask

  // Called at posedge+1; returns at posedge+1 after the flit is taken.
  task automatic send_flit(input logic [1:0] t, input logic [FW-1:0] d,
                           input logic we, input logic rp);
    int   w;
    logic e;
    flit_valid_i = 1'b1;
    flit_type_i  = t;
    flit_i       = d;
    flit_we_i    = we;
    flit_reply_i = rp;
    w = 0;
    @(negedge clk_i);
    while (!flit_ready_o && w < 200) begin
      check_eq("err_while_stalled", err_o, 1'b0);
      w++;
      @(negedge clk_i);
    end
    if (!flit_ready_o) begin
      check_eq("ready_timeout", flit_ready_o, 1'b1);
    end else begin
      model_accept(t, d, we, rp, e);
      acc_cyc = cyc;
      check_eq("err_at_accept", err_o, e);
    end
    @(posedge clk_i);
    #1;
    scramble_idle_inputs();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk_i);
      check_eq("err_idle", err_o, 1'b0);
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ready"}, flit_ready_o, 1'b0);
    check_eq({tag, "_addr"},  address_o, '0);
    check_eq({tag, "_data"},  data_o, '0);
    check_eq({tag, "_sel"},   sel_o, '0);
    check_eq({tag, "_blen"},  burst_len_o, '0);
    check_eq({tag, "_we"},    WE_O, 1'b0);
    check_eq({tag, "_reply"}, reply_for_wb_master_interface_o, 1'b0);
    check_eq({tag, "_valid"}, msg_valid_o, 1'b0);
    check_eq({tag, "_err"},   err_o, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk_i);
    #3;
    rst_n_i = 1'b0;
    #1;
    check_all_zero("reset");
    m_active = 1'b0;
    exp_q.delete();
    repeat (3) @(posedge clk_i);
    #3;
    rst_n_i = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  // Consumer: compares each presented message with the model and acks it.
  initial begin : consumer
    msg_t cur;
    int   hold;
    int   delay;
    hold  = 0;
    delay = 0;
    forever begin
      @(negedge clk_i);
      if (!rst_n_i) begin
        presenting = 1'b0;
        msg_ack_i  = 1'b0;
      end else if (msg_valid_o) begin
        if (!presenting) begin
          check_eq("pending_msgs", exp_q.size(), 1);
          if (exp_q.size() > 0) cur = exp_q.pop_front();
          check_eq("latency", cyc, cur.vcyc);
          presenting = 1'b1;
          hold  = 0;
          delay = (ack_cfg >= 0) ? ack_cfg : int'($urandom_range(0, 3));
        end else begin
          hold++;
        end
        check_eq("addr",      address_o, cur.addr);
        check_eq("data",      data_o, cur.data);
        check_eq("sel",       sel_o, cur.sel);
        check_eq("burst_len", burst_len_o, cur.n);
        check_eq("we",        WE_O, cur.we);
        check_eq("reply",     reply_for_wb_master_interface_o, cur.rp);
        check_eq("ready_lo",  flit_ready_o, 1'b0);
        msg_ack_i = (hold == delay);
      end else begin
        if (presenting) begin
          check_eq("valid_len", hold + 1, delay + 1);
          check_eq("ready_hi",  flit_ready_o, 1'b1);
          drop_cyc   = cyc;
          presenting = 1'b0;
        end
        msg_ack_i = 1'($urandom);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int kind;
    int n;
    scramble_idle_inputs();
    #1;
    check_all_zero("por");
    @(posedge clk_i);
    #3;
    rst_n_i = 1'b1;
    @(negedge clk_i);
    check_eq("ready_after_reset", flit_ready_o, 1'b1);
    check_eq("valid_after_reset", msg_valid_o, 1'b0);
    @(posedge clk_i);
    #1;

    // Read request, ack one cycle after valid.
    ack_cfg = 1;
    send_flit(T_HT, 32'h0000_1A40, 1'b0, 1'b0);
    idle(4);

    // Write burst of three beats.
    ack_cfg = -1;
    send_flit(T_HEAD, 32'h2000, 1'b1, 1'b0);
    send_flit(T_BODY, 32'hA, 1'b0, 1'b1);
    send_flit(T_BODY, 32'hB, 1'b0, 1'b0);
    send_flit(T_TAIL, 32'hC, 1'b0, 1'b0);
    idle(4);

    // Backpressure: full reply packet held for ten cycles, next head waits.
    ack_cfg = 10;
    send_flit(T_HEAD, 32'h4000, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) send_flit(T_BODY, 32'h100 + i, 1'b0, 1'b0);
    send_flit(T_TAIL, 32'h1FF, 1'b0, 1'b0);
    send_flit(T_HEAD, 32'h5000, 1'b1, 1'b0);
    check_eq("bp_head_accept", acc_cyc, drop_cyc);
    ack_cfg = -1;
    send_flit(T_TAIL, 32'h77, 1'b0, 1'b0);
    idle(3);

    // Overflow: five bodies plus tail, truncated to four beats.
    send_flit(T_HEAD, 32'h6000, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) send_flit(T_BODY, 32'h11 + i, 1'b0, 1'b0);
    send_flit(T_TAIL, 32'h16, 1'b0, 1'b0);
    idle(4);

    // Protocol errors: stray body, then head aborting an open packet.
    send_flit(T_BODY, 32'hDEAD, 1'b0, 1'b0);
    idle(3);
    send_flit(T_HEAD, 32'h7000, 1'b0, 1'b0);
    send_flit(T_BODY, 32'h99, 1'b0, 1'b0);
    send_flit(T_HEAD, 32'h3000, 1'b1, 1'b0);
    send_flit(T_TAIL, 32'h5, 1'b0, 1'b0);
    idle(4);

    // Reset in the middle of a packet.
    send_flit(T_HEAD, 32'h8000, 1'b1, 1'b1);
    send_flit(T_BODY, 32'h1, 1'b0, 1'b0);
    send_flit(T_BODY, 32'h2, 1'b0, 1'b0);
    do_reset();
    send_flit(T_HT, 32'h9ABC, 1'b1, 1'b1);
    idle(4);

    // Random traffic.
    for (int p = 0; p < 60; p++) begin
      kind = $urandom_range(0, 9);
      if (kind < 3) begin
        send_flit(T_HT, $urandom, 1'($urandom), 1'($urandom));
      end else if (kind == 3) begin
        send_flit($urandom_range(0, 1) ? T_BODY : T_TAIL, $urandom, 1'($urandom), 1'($urandom));
      end else begin
        n = $urandom_range(0, 6);
        send_flit(T_HEAD, $urandom, 1'($urandom), 1'($urandom));
        for (int i = 0; i < n; i++) begin
          send_flit(T_BODY, $urandom, 1'($urandom), 1'($urandom));
          if ($urandom_range(0, 3) == 0) idle(1);
        end
        if (kind != 4) send_flit(T_TAIL, $urandom, 1'($urandom), 1'($urandom));
      end
      idle($urandom_range(0, 2));
    end
    send_flit(T_HT, 32'hF00D, 1'b0, 1'b1);

    for (int w = 0; w < 200; w++) begin
      if (exp_q.size() == 0 && !presenting && !msg_valid_o) break;
      @(posedge clk_i);
      #1;
    end
    idle(2);
    check_eq("drain", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
